gyro_uart_frame_rx: RTL and testbench
=====================================

Name: gyro_uart_frame_rx

Overview:
- Receive-side counterpart of the gyro telemetry UART link: deserialises 8N1 UART and reassembles the repeating 8-byte gyro frame (x lo, x hi, y lo, y hi, z lo, z hi, 0x55, 0x55).
- Presents the X, Y and Z axis words only after the frame's trailing sync pair has been verified.
- Sits on a host-side or loopback FPGA fed from a PMOD pin; also used as the bench checker for the transmit path.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- SYNC_BYTE, 8'h55, value of each of the two trailing sync bytes.

Ports:
- clockIN  in  1  system clock, all logic on posedge.
- nRxResetIN  in  1  reset, asynchronous assert, active-low.
- rxIN  in  1  UART serial input, idle high, asynchronous to clockIN.
- xAxisOUT  out  16  last committed X word, {hi,lo}.
- yAxisOUT  out  16  last committed Y word.
- zAxisOUT  out  16  last committed Z word.
- frameValidOUT  out  1  one-cycle pulse when the axis outputs update.
- frameErrorOUT  out  1  one-cycle pulse on a sync mismatch or stop error while locked.
- syncLockedOUT  out  1  high while the frame FSM is in DATA/SYNC0/SYNC1.
- byteValidOUT  out  1  one-cycle pulse per good received byte.
- byteDataOUT  out  8  received byte, held until the next byteValidOUT.
- stopErrorOUT  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (nRxResetIN=0, asynchronous):
  - All outputs 0.
  - Synchroniser flops set to 1.
  - Both FSMs go to their first state: IDLE for the byte FSM, HUNT0 for the frame FSM.
- Input synchronisation: 2-flop synchroniser on rxIN; all decisions use the second-stage value (rxs).
- Byte FSM (IDLE, START, DATA, STOP):
  - The bit counter is wide enough for CLKS_PER_BIT-1.
  - IDLE: when rxs=0, load the counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles (integer divide), sample rxs. If 1, treat as a glitch and return to IDLE with no output. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into the byte register.
  - STOP: sample one bit period after the last data bit.
    - rxs=1: update byteDataOUT and pulse byteValidOUT on the next edge.
    - rxs=0: pulse stopErrorOUT; byteDataOUT is unchanged and no byteValidOUT.
    - Either way, return to IDLE.
  - IDLE re-arms immediately. A start edge during a low stop bit is not waited out: a low line is taken as a new start.
  - Latency: byteValidOUT is asserted 1 cycle after the stop-bit mid-sample.
- Frame FSM (HUNT0, HUNT1, DATA, SYNC0, SYNC1): advances only on byteValidOUT or stopErrorOUT.
  - HUNT0: SYNC_BYTE goes to HUNT1; any other byte stays in HUNT0.
  - HUNT1: SYNC_BYTE goes to DATA with idx=0; any other byte goes to HUNT0.
  - DATA: store the byte into shadow[idx] (idx 0..5, a 3-bit counter). After idx=5, go to SYNC0.
  - SYNC0: SYNC_BYTE goes to SYNC1. Anything else pulses frameErrorOUT and goes to HUNT0.
  - SYNC1: SYNC_BYTE commits the shadow registers to the outputs (x={s1,s0}, y={s3,s2}, z={s5,s4}), pulses frameValidOUT in the same cycle the outputs change, and goes to DATA with idx=0. Anything else pulses frameErrorOUT and goes to HUNT0.
  - stopErrorOUT in DATA/SYNC0/SYNC1 pulses frameErrorOUT and goes to HUNT0. In HUNT0/HUNT1 it goes to HUNT0 with no frameErrorOUT.
  - Outputs never update from a partial or unverified frame. Shadow registers are not cleared on error.
  - Known false lock: a data byte equal to 0x55 adjacent to the sync pair can cause a lock one byte early. This is detected at the next SYNC0/SYNC1 check, which returns to hunt; at most one frameErrorOUT per false lock.
- syncLockedOUT is registered and equals (state in {DATA, SYNC0, SYNC1}).
- Mid-operation reset: immediate return to reset values. The next frame must be hunted again; the first commit needs sync, 6 data bytes and sync.

Decomposition:
- Shared package gyro_link_pkg:
  - SYNC_BYTE default.
  - FRAME_DATA_BYTES=6, FRAME_LEN=8.
  - Byte FSM and frame FSM state encodings.
  - The byte order (x lo first) as named index constants. The same constants are to be used by the transmit side.
- Sub-module uart_rx_byte holds the synchroniser and byte FSM. Its ports are clockIN, nRxResetIN, rxIN, byteValidOUT, byteDataOUT, stopErrorOUT.
- The frame FSM lives in gyro_uart_frame_rx.

Test Plan (CLKS_PER_BIT=16):
- Clean lock: send 55 55 34 12 78 56 BC 9A 55 55 → one frameValidOUT after the last stop bit. x=0x1234, y=0x5678, z=0x9ABC. syncLockedOUT goes 1 after the 2nd byte.
- Streaming: 3 back-to-back frames with x=0x0001, 0x0002, 0x0003 → 3 frameValidOUT pulses, each following its frame's sync pair. x tracks each frame; no frameErrorOUT.
- Sync corruption: lock, then send a frame whose 2nd sync byte is 0x54 → frameErrorOUT=1, outputs keep the prior values, syncLockedOUT=0. The next clean 55 55 plus frame commits.
- Stop error: while locked, drive the stop bit low on the y lo byte → stopErrorOUT and frameErrorOUT pulse, no byteValidOUT for that byte, FSM returns to HUNT0.
- Glitch rejection: a 4-cycle low pulse on an idle rxIN → no byteValidOUT, byte FSM back in IDLE.
- Async reset mid-byte: deassert nRxResetIN during bit 3 of z hi → all outputs 0 immediately. A later full 55 55 + frame decodes correctly.

Source files
------------

// File: rtl/gyro_link_pkg.sv
// Shared definitions for the gyro telemetry UART link: frame layout, sync value
// and the state encodings used by the receive path.
package gyro_link_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h55;
    localparam int unsigned FRAME_DATA_BYTES  = 6;
    localparam int unsigned FRAME_LEN         = 8;

    // Byte order on the wire; the transmit side uses the same indices.
    localparam int unsigned IDX_X_LO = 0;
    localparam int unsigned IDX_X_HI = 1;
    localparam int unsigned IDX_Y_LO = 2;
    localparam int unsigned IDX_Y_HI = 3;
    localparam int unsigned IDX_Z_LO = 4;
    localparam int unsigned IDX_Z_HI = 5;

    typedef enum logic [1:0] {
        BYTE_IDLE  = 2'd0,
        BYTE_START = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_STOP  = 2'd3
    } byte_state_t;

    typedef enum logic [2:0] {
        FRM_HUNT0 = 3'd0,
        FRM_HUNT1 = 3'd1,
        FRM_DATA  = 3'd2,
        FRM_SYNC0 = 3'd3,
        FRM_SYNC1 = 3'd4
    } frame_state_t;

    function automatic logic is_locked(input frame_state_t s);
        return (s == FRM_DATA) || (s == FRM_SYNC0) || (s == FRM_SYNC1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop input synchroniser plus a mid-bit sampling
// byte FSM. Emits one-cycle pulses for good bytes and for low stop bits.
module uart_rx_byte
    import gyro_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clockIN,
    input  logic       nRxResetIN,
    input  logic       rxIN,
    output logic       byteValidOUT,
    output logic [7:0] byteDataOUT,
    output logic       stopErrorOUT
);

    localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic          r_meta;
    logic          r_rxs;
    byte_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic [7:0]    r_byte_data;
    logic          r_stop_err;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            r_meta <= 1'b1;
            r_rxs  <= 1'b1;
        end else begin
            r_meta <= rxIN;
            r_rxs  <= r_meta;
        end
    end

    // Byte FSM: half-bit wait validates the start bit, then full-bit spacing.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            r_state      <= BYTE_IDLE;
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_byte_data  <= 8'h00;
            r_stop_err   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            case (r_state)
                BYTE_IDLE: begin
                    if (!r_rxs) begin
                        r_cnt   <= '0;
                        r_state <= BYTE_START;
                    end
                end
                BYTE_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_bit   <= 3'd0;
                        r_state <= r_rxs ? BYTE_IDLE : BYTE_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                BYTE_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= BYTE_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                BYTE_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= BYTE_IDLE;
                        if (r_rxs) begin
                            r_byte_data  <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_stop_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= BYTE_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign byteValidOUT = r_byte_valid;
    assign byteDataOUT  = r_byte_data;
    assign stopErrorOUT = r_stop_err;

endmodule

// File: rtl/gyro_uart_frame_rx.sv
// Gyro telemetry frame receiver: hunts the 0x55 0x55 sync pair, collects six
// axis bytes and publishes X/Y/Z only once the trailing sync pair checks out.
module gyro_uart_frame_rx
    import gyro_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clockIN,
    input  logic        nRxResetIN,
    input  logic        rxIN,
    output logic [15:0] xAxisOUT,
    output logic [15:0] yAxisOUT,
    output logic [15:0] zAxisOUT,
    output logic        frameValidOUT,
    output logic        frameErrorOUT,
    output logic        syncLockedOUT,
    output logic        byteValidOUT,
    output logic [7:0]  byteDataOUT,
    output logic        stopErrorOUT
);

    logic         w_byte_valid;
    logic [7:0]   w_byte_data;
    logic         w_stop_err;

    frame_state_t r_state;
    logic [2:0]   r_idx;
    logic [7:0]   r_shadow [FRAME_DATA_BYTES];
    logic [15:0]  r_x;
    logic [15:0]  r_y;
    logic [15:0]  r_z;
    logic         r_frame_valid;
    logic         r_frame_err;
    logic         r_locked;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clockIN      (clockIN),
        .nRxResetIN   (nRxResetIN),
        .rxIN         (rxIN),
        .byteValidOUT (w_byte_valid),
        .byteDataOUT  (w_byte_data),
        .stopErrorOUT (w_stop_err)
    );

    // Frame FSM; r_locked is written alongside every state change so it always matches r_state.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            r_state       <= FRM_HUNT0;
            r_idx         <= 3'd0;
            r_x           <= 16'h0000;
            r_y           <= 16'h0000;
            r_z           <= 16'h0000;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_locked      <= 1'b0;
            for (int i = 0; i < FRAME_DATA_BYTES; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_stop_err) begin
                r_frame_err <= is_locked(r_state);
                r_state     <= FRM_HUNT0;
                r_locked    <= 1'b0;
            end else if (w_byte_valid) begin
                case (r_state)
                    FRM_HUNT0: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_state <= FRM_HUNT1;
                        end
                    end
                    FRM_HUNT1: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_state  <= FRM_DATA;
                            r_idx    <= 3'd0;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= FRM_HUNT0;
                        end
                    end
                    FRM_DATA: begin
                        r_shadow[r_idx] <= w_byte_data;
                        if (r_idx == 3'(FRAME_DATA_BYTES - 1)) begin
                            r_state <= FRM_SYNC0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                    FRM_SYNC0: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_state <= FRM_SYNC1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= FRM_HUNT0;
                            r_locked    <= 1'b0;
                        end
                    end
                    FRM_SYNC1: begin
                        if (w_byte_data == SYNC_BYTE) begin
                            r_x           <= {r_shadow[IDX_X_HI], r_shadow[IDX_X_LO]};
                            r_y           <= {r_shadow[IDX_Y_HI], r_shadow[IDX_Y_LO]};
                            r_z           <= {r_shadow[IDX_Z_HI], r_shadow[IDX_Z_LO]};
                            r_frame_valid <= 1'b1;
                            r_state       <= FRM_DATA;
                            r_idx         <= 3'd0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= FRM_HUNT0;
                            r_locked    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= FRM_HUNT0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign xAxisOUT      = r_x;
    assign yAxisOUT      = r_y;
    assign zAxisOUT      = r_z;
    assign frameValidOUT = r_frame_valid;
    assign frameErrorOUT = r_frame_err;
    assign syncLockedOUT = r_locked;
    assign byteValidOUT  = w_byte_valid;
    assign byteDataOUT   = w_byte_data;
    assign stopErrorOUT  = w_stop_err;

endmodule

// File: tb/tb_gyro_uart_frame_rx.sv
// Directed bench for gyro_uart_frame_rx at 16 clocks per bit; committed frames
// are checked against a queue of expected {x,y,z} words.
module tb_gyro_uart_frame_rx;

    localparam int unsigned CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] x_axis;
    logic [15:0] y_axis;
    logic [15:0] z_axis;
    logic        fv;
    logic        fe;
    logic        sl;
    logic        bv;
    logic [7:0]  bd;
    logic        se;

    int checks = 0;
    int errors = 0;
    int n_fv = 0;
    int n_fe = 0;
    int n_bv = 0;
    int n_se = 0;
    int b_fv, b_fe, b_bv, b_se;
    logic [47:0] exp_q [$];

    gyro_uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'h55)
    ) dut (
        .clockIN       (clk),
        .nRxResetIN    (rst_n),
        .rxIN          (rx),
        .xAxisOUT      (x_axis),
        .yAxisOUT      (y_axis),
        .zAxisOUT      (z_axis),
        .frameValidOUT (fv),
        .frameErrorOUT (fe),
        .syncLockedOUT (sl),
        .byteValidOUT  (bv),
        .byteDataOUT   (bd),
        .stopErrorOUT  (se)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse counters and frame scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (bv) n_bv++;
        if (se) n_se++;
        if (fe) n_fe++;
        if (fv) begin
            n_fv++;
            if (exp_q.size() == 0) begin
                chk("frame_unexpected", 48'(exp_q.size()), 48'd1);
            end else begin
                chk("frame_xyz", {x_axis, y_axis, z_axis}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = stop;
        wait_bit();
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] fx, input logic [15:0] fy, input logic [15:0] fz,
                              input logic [7:0] s0, input logic [7:0] s1, input bit commit);
        if (commit) exp_q.push_back({fx, fy, fz});
        send_byte(fx[7:0], 1'b1);
        send_byte(fx[15:8], 1'b1);
        send_byte(fy[7:0], 1'b1);
        send_byte(fy[15:8], 1'b1);
        send_byte(fz[7:0], 1'b1);
        send_byte(fz[15:8], 1'b1);
        send_byte(s0, 1'b1);
        send_byte(s1, 1'b1);
    endtask

    task automatic snap();
        @(negedge clk);
        #1;
        b_fv = n_fv;
        b_fe = n_fe;
        b_bv = n_bv;
        b_se = n_se;
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        settle(4);
        chk("reset_axes", {x_axis, y_axis, z_axis}, 48'd0);
        chk("reset_flags", 48'({fv, fe, sl, bv, se, bd}), 48'd0);
        rst_n = 1'b1;
        settle(4);

        // Clean lock
        snap();
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        settle(1);
        chk("lock_after_sync", 48'(sl), 48'd1);
        send_frame(16'h1234, 16'h5678, 16'h9ABC, 8'h55, 8'h55, 1'b1);
        settle(4);
        chk("lock_fv_count", 48'(n_fv - b_fv), 48'd1);
        chk("lock_axes", {x_axis, y_axis, z_axis}, 48'h1234_5678_9ABC);

        // Streaming
        snap();
        for (int k = 1; k <= 3; k++) begin
            send_frame(16'(k), 16'(16'h1000 + k), 16'(16'h2000 + k), 8'h55, 8'h55, 1'b1);
        end
        settle(4);
        chk("stream_fv_count", 48'(n_fv - b_fv), 48'd3);
        chk("stream_fe_count", 48'(n_fe - b_fe), 48'd0);
        chk("stream_x_last", 48'(x_axis), 48'h0003);

        // Sync corruption then recovery
        snap();
        send_frame(16'h1111, 16'h2222, 16'h3333, 8'h55, 8'h54, 1'b0);
        settle(4);
        chk("corrupt_fe_count", 48'(n_fe - b_fe), 48'd1);
        chk("corrupt_axes_held", {x_axis, y_axis, z_axis}, 48'h0003_1003_2003);
        chk("corrupt_unlocked", 48'(sl), 48'd0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        send_frame(16'hBBAA, 16'hDDCC, 16'hFFEE, 8'h55, 8'h55, 1'b1);
        settle(4);
        chk("recover_fv_count", 48'(n_fv - b_fv), 48'd1);

        // Stop error on y lo while locked
        snap();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        settle(3 * CPB);
        chk("stop_se_count", 48'(n_se - b_se), 48'd1);
        chk("stop_fe_count", 48'(n_fe - b_fe), 48'd1);
        chk("stop_bv_count", 48'(n_bv - b_bv), 48'd2);
        chk("stop_data_held", 48'(bd), 48'h22);
        chk("stop_unlocked", 48'(sl), 48'd0);

        // Glitch rejection, then a good byte proves the receiver re-armed
        snap();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        settle(3 * CPB);
        chk("glitch_bv_count", 48'(n_bv - b_bv), 48'd0);
        chk("glitch_se_count", 48'(n_se - b_se), 48'd0);
        send_byte(8'hA5, 1'b1);
        settle(2);
        chk("post_glitch_byte", 48'(bd), 48'hA5);
        chk("post_glitch_bv", 48'(n_bv - b_bv), 48'd1);

        // Asynchronous reset during bit 3 of z hi
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h05, 1'b1);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 3; i++) begin
            rx = 1'b0;
            wait_bit();
        end
        rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_axes", {x_axis, y_axis, z_axis}, 48'd0);
        chk("midreset_flags", 48'({fv, fe, sl, bv, se, bd}), 48'd0);
        settle(5);
        rst_n = 1'b1;
        settle(2 * CPB);
        snap();
        send_byte(8'h55, 1'b1);
        send_byte(8'h55, 1'b1);
        send_frame(16'h4321, 16'h8765, 16'hCBA9, 8'h55, 8'h55, 1'b1);
        settle(4);
        chk("after_reset_fv_count", 48'(n_fv - b_fv), 48'd1);
        chk("after_reset_axes", {x_axis, y_axis, z_axis}, 48'h4321_8765_CBA9);
        chk("queue_drained", 48'(exp_q.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
